// File: rtl/compare_pkg.sv
// Shared types for the result compare checker: FSM state encoding and the
// compare_done_reg status codes.
package compare_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CMP_NONE     = 4'b0000;
    localparam logic [3:0] CMP_MATCH    = 4'b0101;
    localparam logic [3:0] CMP_MISMATCH = 4'b1010;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that saturates at all-ones instead of
// wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is written with <= so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/result_compare_checker.sv
// Compares DSP products against an expected-value RAM, one sample per valid.
// Define MISMATCH_STOP_EN to end the run at the first mismatch.
module result_compare_checker
    import compare_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int P_W    = 38,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_samples,
    input  logic [P_W-1:0]    p_i,
    input  logic              p_valid_i,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] dout_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  match_count,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [3:0]        compare_done_reg
);

    state_t state, state_nxt;

    // One extra bit so a full 2^ADDR_W run (num_samples == 0) is representable.
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] p_dly;
    logic              p_dly_vld;
    logic [ADDR_W-1:0] addr_dly;
    logic              fail_seen;

    logic start_ok, cmp_match, cmp_miss, stop_now, accept, last_accept;
    logic unused_p_hi;

    assign unused_p_hi = ^p_i[P_W-1:DATA_W];

    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign cmp_match = p_dly_vld && (p_dly == dout_i);
    assign cmp_miss  = p_dly_vld && (p_dly != dout_i);

`ifdef MISMATCH_STOP_EN
    assign stop_now = cmp_miss;
`else
    assign stop_now = 1'b0;
`endif

    // A sample arriving in the same cycle as a stopping mismatch is refused.
    assign accept      = (state == ST_RUN) && p_valid_i && !stop_now;
    assign last_accept = accept && (remaining == (ADDR_W+1)'(1));

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
            ST_RUN:   if (last_accept || stop_now) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!p_dly_vld) state_nxt = ST_DONE;
            ST_DONE:  if (start_ok) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_addr        <= '0;
            remaining        <= '0;
            p_dly            <= '0;
            p_dly_vld        <= 1'b0;
            addr_dly         <= '0;
            fail_seen        <= 1'b0;
            pass             <= 1'b0;
            done             <= 1'b0;
            first_fail_addr  <= '0;
            compare_done_reg <= CMP_NONE;
        end else if (start_ok) begin
            read_addr        <= '0;
            remaining        <= (num_samples == '0) ? {1'b1, {ADDR_W{1'b0}}}
                                                    : {1'b0, num_samples};
            p_dly_vld        <= 1'b0;
            fail_seen        <= 1'b0;
            pass             <= 1'b1;
            done             <= 1'b0;
            first_fail_addr  <= '0;
            compare_done_reg <= CMP_NONE;
        end else begin
            p_dly_vld <= accept;
            if (accept) begin
                p_dly     <= p_i[DATA_W-1:0];
                addr_dly  <= read_addr;
                read_addr <= read_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (p_dly_vld) begin
                compare_done_reg <= cmp_match ? CMP_MATCH : CMP_MISMATCH;
            end
            if (cmp_miss) begin
                pass <= 1'b0;
                if (!fail_seen) begin
                    fail_seen       <= 1'b1;
                    first_fail_addr <= addr_dly;
                end
            end
            if ((state == ST_DRAIN) && (state_nxt == ST_DONE)) begin
                done <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .inc   (cmp_match),
        .count (match_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .inc   (cmp_miss),
        .count (mismatch_count)
    );

endmodule

// File: doc/result_compare_checker.md
RESULT_COMPARE_CHECKER -- requirements
Module: result_compare_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, the expected-RAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, the compared data width.
REQ-003 SHALL have parameter P_W, default 38, the product input width.
REQ-004 SHALL have parameter CNT_W, default 16, the match/mismatch counter width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins a check run.
REQ-008 SHALL have port num_samples  input  ADDR_W  samples per run, 0 means 2^ADDR_W.
REQ-009 SHALL have port p_i  input  P_W  accumulator product from the DSP stage.
REQ-010 SHALL have port p_valid_i  input  1  p_i holds a new sample this cycle.
REQ-011 SHALL have port read_addr  output  ADDR_W  expected-RAM read address.
REQ-012 SHALL have port dout_i  input  DATA_W  expected-RAM read data, valid one cycle after read_addr.
REQ-013 SHALL have port busy / done / pass  output  1 each  run active / run finished (sticky) / no mismatch.
REQ-014 SHALL have port match_count, mismatch_count  output  CNT_W each  compare tallies.
REQ-015 SHALL have port first_fail_addr  output  ADDR_W  address of the first mismatch.
REQ-016 SHALL have port compare_done_reg  output  4  4'b0101 last compare matched, 4'b1010 mismatched, 4'b0000 none yet.

Function
REQ-017 SHALL implement FSM IDLE -> RUN (start) -> DRAIN (last sample accepted) -> DONE (pipeline empty) -> RUN (start) or IDLE (never on its own).
REQ-018 SHALL ignore start while in RUN or DRAIN.
REQ-019 SHALL, on start, clear counters, first_fail_addr, compare_done_reg, pass=1, done=0, read_addr=0.
REQ-020 SHALL in RUN, per p_valid_i cycle: capture p_i[DATA_W-1:0] in a one-stage delay register, present the current read_addr, then increment read_addr.
REQ-021 SHALL compare the delayed p against dout_i one cycle later (latency 1 from p_valid_i to count/flag update).
REQ-022 SHALL ignore p_i[P_W-1:DATA_W] in the compare.
REQ-023 SHALL ignore p_valid_i outside RUN.
REQ-024 SHALL on mismatch increment mismatch_count, clear pass, and record first_fail_addr only on the first mismatch of the run.
REQ-025 SHALL saturate both counters at all-ones, never wrap.
REQ-026 SHALL wrap read_addr from 2^ADDR_W-1 to 0 when num_samples=0.
REQ-027 SHALL assert busy in RUN and DRAIN only; done is set on entry to DONE and held until the next start.
REQ-028 SHALL sample num_samples only at start.

Reset
REQ-029 SHALL on reset low, asynchronously: state IDLE, all outputs 0 (pass=0), delay register invalid.
REQ-030 SHALL abort a run on reset mid-operation; no partial result survives.

Configuration
REQ-031 SHALL, with MISMATCH_STOP_EN defined, go RUN/DRAIN -> DRAIN -> DONE after the first mismatch, accepting no further samples; without it, the run completes all num_samples.

Structure
REQ-032 SHALL place the FSM state enum and the 4'b0101/4'b1010/4'b0000 codes in shared package compare_pkg.
REQ-033 SHALL use one sub-module, sat_counter (CNT_W, inc, clear), instantiated twice.

Verification
REQ-034 SHALL cover: num_samples=4, all match -> match_count=4, mismatch_count=0, pass=1, done=1, compare_done_reg=4'b0101.
REQ-035 SHALL cover: num_samples=8, mismatch at addresses 3 and 6 -> mismatch_count=2, first_fail_addr=3, pass=0, compare_done_reg=4'b1010 after address 6.
REQ-036 SHALL cover: num_samples=0 with 512 valid samples -> read_addr wraps to 0, match_count=512, done=1.
REQ-037 SHALL cover: reset low at sample 5 of 10 -> all outputs 0, state IDLE; a new start then runs cleanly.
REQ-038 SHALL cover: MISMATCH_STOP_EN defined, mismatch at address 2 of 8 -> done=1 with match_count=2, mismatch_count=1, later p_valid_i ignored.
REQ-039 SHALL cover: start pulsed during RUN, plus p_valid_i in IDLE -> no effect on counts or read_addr.
